// File: rtl/clk_en_ctrl_pkg.sv
// Shared constants and state encoding for the slow-domain clock-enable controller.
// Core-side logic and the test harness import these so both agree on defaults.
package clk_en_ctrl_pkg;

  localparam int unsigned CE_DIV_W       = 8;
  localparam int unsigned CE_STEP_W      = 16;
  localparam int unsigned CE_DEFAULT_DIV = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } ce_state_e;

endpackage

// File: rtl/clk_en_period_cnt.sv
// Period counter: counts 0..cur_div-1 while active and flags the last cycle of a period.
// Held at 0 while inactive; restart forces the next period to start from 0.
module clk_en_period_cnt
  import clk_en_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = CE_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             restart,
  input  logic [DIV_W-1:0] cur_div,
  output logic             boundary_c
);

  logic [DIV_W-1:0] cnt;

  // cur_div is never 0, so cur_div-1 cannot underflow
  assign boundary_c = (cnt == (cur_div - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || restart || boundary_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: issues a one-cycle core_ce every cur_div clocks, with
// boundary-aligned ratio updates and debug halt / multi-step for the core.
module clk_en_ctrl
  import clk_en_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W       = CE_DIV_W,
  parameter int unsigned DEFAULT_DIV = CE_DEFAULT_DIV,
  parameter int unsigned STEP_W      = CE_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  input  logic              halt_req,
  input  logic              step_valid,
  input  logic [STEP_W-1:0] step_cnt,
  output logic              step_ready,
  output logic              core_ce,
  output logic              halted,
  output logic [DIV_W-1:0]  cur_div
);

  ce_state_e         state;
  logic              pend_vld;
  logic [DIV_W-1:0]  pend_div;
  logic [STEP_W-1:0] step_left;
  logic              boundary_c;
  logic              active_c;
  logic              apply_c;

  assign active_c = (state != HALTED);
  // Pending ratio lands on a period boundary, or right away while frozen
  assign apply_c  = pend_vld && (boundary_c || !active_c);

  clk_en_period_cnt #(
    .DIV_W (DIV_W)
  ) u_period_cnt (
    .clk        (clk),
    .rst        (rst),
    .active     (active_c),
    .restart    (apply_c),
    .cur_div    (cur_div),
    .boundary_c (boundary_c)
  );

  // Run / halt / step sequencing with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      step_left  <= '0;
      core_ce    <= 1'b0;
      halted     <= 1'b0;
      step_ready <= 1'b0;
    end else begin
      core_ce <= 1'b0;
      case (state)
        RUN: begin
          if (boundary_c) begin
            core_ce <= 1'b1;
            if (halt_req) begin
              state      <= HALTED;
              halted     <= 1'b1;
              step_ready <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state      <= RUN;
            halted     <= 1'b0;
            step_ready <= 1'b0;
          end else if (step_valid && (step_cnt != '0)) begin
            state      <= STEP;
            step_left  <= step_cnt;
            halted     <= 1'b0;
            step_ready <= 1'b0;
          end
        end
        STEP: begin
          if (boundary_c) begin
            core_ce   <= 1'b1;
            step_left <= step_left - STEP_W'(1);
            if (step_left == STEP_W'(1)) begin
              if (halt_req) begin
                state      <= HALTED;
                halted     <= 1'b1;
                step_ready <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
        end
        default: begin
          state      <= RUN;
          halted     <= 1'b0;
          step_ready <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry ratio holding register; cfg_ready mirrors ~pend_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_div  <= DIV_W'(DEFAULT_DIV);
      cur_div   <= DIV_W'(DEFAULT_DIV);
      cfg_ready <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      pend_vld  <= 1'b1;
      pend_div  <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      cfg_ready <= 1'b0;
    end else if (apply_c) begin
      cur_div   <= pend_div;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
    end
  end

endmodule
